// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud tick generator: oversample tick, bit tick, legacy baud_clk.
// Optional auto-baud measurement FSM is compiled in when BAUD_AUTOBAUD_EN is defined.
module uart_baud_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DIV_RST  = 325,
    parameter int FRAC_RST = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    input  logic                    sync_clr,
    input  logic                    rxd,
`ifdef BAUD_AUTOBAUD_EN
    input  logic                    autobaud_start,
    output logic                    autobaud_busy,
    output logic                    autobaud_done,
`endif
    output logic                    tick_ovs,
    output logic                    tick_bit,
    output logic                    baud_clk,
    output logic [DIV_W+FRAC_W-1:0] cur_div
);

    localparam int LOG2_OVS = $clog2(OVS);
    localparam logic [LOG2_OVS-1:0] OVS_LAST   = LOG2_OVS'(OVS - 1);
    localparam logic [DIV_W-1:0]    DIV_RST_V  = DIV_W'(DIV_RST);
    localparam logic [FRAC_W-1:0]   FRAC_RST_V = FRAC_W'(FRAC_RST);

    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic [LOG2_OVS-1:0] ovs_cnt_q, ovs_cnt_d;
    logic                tick_ovs_q, tick_ovs_d;
    logic                tick_bit_q, tick_bit_d;
    logic                baud_clk_q, baud_clk_d;
    logic [DIV_W-1:0]    act_int_q, act_int_d;
    logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
    logic [DIV_W-1:0]    shd_int_q, shd_int_d;
    logic [FRAC_W-1:0]   shd_frac_q, shd_frac_d;

    logic [DIV_W-1:0]    eff_div_s;
    logic [FRAC_W:0]     frac_sum_s;
    logic [DIV_W-1:0]    last_cnt_s;
    logic                period_end_s;

    // Auto-baud hand-off into the main datapath (tied off when the feature is absent)
    logic                ab_load_s;
    logic [DIV_W-1:0]    ab_int_s;
    logic [FRAC_W-1:0]   ab_frac_s;

    // Period length: clamped integer part plus the carry of this period's fraction add.
    // last_cnt fits DIV_W bits because D-1 <= 2^DIV_W-2 before the carry is added.
    always_comb begin
        if (act_int_q < DIV_W'(2)) begin
            eff_div_s = DIV_W'(2);
        end else begin
            eff_div_s = act_int_q;
        end
        frac_sum_s   = {1'b0, acc_q} + {1'b0, act_frac_q};
        last_cnt_s   = eff_div_s - DIV_W'(1) + DIV_W'(frac_sum_s[FRAC_W]);
        period_end_s = (cnt_q >= last_cnt_s);
    end

    // Next-state for counters, ticks and divisor registers
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ovs_cnt_d  = ovs_cnt_q;
        baud_clk_d = baud_clk_q;
        tick_ovs_d = 1'b0;
        tick_bit_d = 1'b0;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;

        if (ab_load_s) begin
            shd_int_d  = ab_int_s;
            shd_frac_d = ab_frac_s;
        end else if (div_load) begin
            shd_int_d  = div_int;
            shd_frac_d = div_frac;
        end else begin
            shd_int_d  = shd_int_q;
            shd_frac_d = shd_frac_q;
        end

        // Using the next shadow value lets a same-cycle div_load take effect at once
        if (sync_clr || ab_load_s) begin
            cnt_d      = '0;
            acc_d      = '0;
            ovs_cnt_d  = '0;
            act_int_d  = shd_int_d;
            act_frac_d = shd_frac_d;
        end else if (!en) begin
            act_int_d  = shd_int_d;
            act_frac_d = shd_frac_d;
        end else if (period_end_s) begin
            cnt_d      = '0;
            acc_d      = frac_sum_s[FRAC_W-1:0];
            ovs_cnt_d  = ovs_cnt_q + LOG2_OVS'(1);
            tick_ovs_d = 1'b1;
            tick_bit_d = (ovs_cnt_q == OVS_LAST);
            baud_clk_d = ~baud_clk_q;
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Datapath state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            ovs_cnt_q  <= '0;
            tick_ovs_q <= 1'b0;
            tick_bit_q <= 1'b0;
            baud_clk_q <= 1'b0;
            act_int_q  <= DIV_RST_V;
            act_frac_q <= FRAC_RST_V;
            shd_int_q  <= DIV_RST_V;
            shd_frac_q <= FRAC_RST_V;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovs_cnt_q  <= ovs_cnt_d;
            tick_ovs_q <= tick_ovs_d;
            tick_bit_q <= tick_bit_d;
            baud_clk_q <= baud_clk_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
        end
    end

    assign tick_ovs = tick_ovs_q;
    assign tick_bit = tick_bit_q;
    assign baud_clk = baud_clk_q;
    assign cur_div  = {act_int_q, act_frac_q};

`ifdef BAUD_AUTOBAUD_EN
    localparam int MEAS_W = DIV_W + LOG2_OVS;

    typedef enum logic [1:0] {
        AB_IDLE      = 2'd0,
        AB_WAIT_FALL = 2'd1,
        AB_MEASURE   = 2'd2,
        AB_LOAD      = 2'd3
    } ab_state_t;

    ab_state_t                ab_state_q, ab_state_d;
    logic                     rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [MEAS_W-1:0]        meas_q, meas_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ab_abort_s;
    logic                     rxd_fall_s;
    logic [LOG2_OVS+FRAC_W-1:0] ab_frac_ext_s;

    // rxd two-flop synchroniser plus one delayed copy for edge detection; line idles high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign rxd_fall_s = rxd_prev_q & ~rxd_sync_q;
    assign ab_abort_s = sync_clr | div_load;

    // Auto-baud FSM: measure one low pulse of OVS x divisor cycles
    always_comb begin
        ab_state_d = ab_state_q;
        meas_d     = meas_q;
        done_d     = 1'b0;
        case (ab_state_q)
            AB_IDLE: begin
                if (autobaud_start) begin
                    ab_state_d = AB_WAIT_FALL;
                end else begin
                    ab_state_d = AB_IDLE;
                end
            end
            AB_WAIT_FALL: begin
                if (ab_abort_s) begin
                    ab_state_d = AB_IDLE;
                end else if (rxd_fall_s) begin
                    meas_d     = MEAS_W'(1);
                    ab_state_d = AB_MEASURE;
                end else begin
                    ab_state_d = AB_WAIT_FALL;
                end
            end
            AB_MEASURE: begin
                if (ab_abort_s) begin
                    ab_state_d = AB_IDLE;
                end else if (rxd_sync_q) begin
                    ab_state_d = AB_LOAD;
                end else if (meas_q == {MEAS_W{1'b1}}) begin
                    ab_state_d = AB_IDLE;
                end else begin
                    meas_d = meas_q + MEAS_W'(1);
                end
            end
            AB_LOAD: begin
                done_d     = 1'b1;
                ab_state_d = AB_IDLE;
            end
            default: begin
                ab_state_d = AB_IDLE;
            end
        endcase
        busy_d = (ab_state_d != AB_IDLE);
    end

    // Auto-baud state and status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ab_state_q <= AB_IDLE;
            meas_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ab_state_q <= ab_state_d;
            meas_q     <= meas_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Low LOG2_OVS bits of the count are the fraction of a divisor, rescaled to FRAC_W bits
    assign ab_frac_ext_s = {meas_q[LOG2_OVS-1:0], {FRAC_W{1'b0}}} >> LOG2_OVS;
    assign ab_frac_s     = ab_frac_ext_s[FRAC_W-1:0];
    assign ab_int_s      = meas_q[MEAS_W-1:LOG2_OVS];
    assign ab_load_s     = (ab_state_q == AB_LOAD);
    assign autobaud_busy = busy_q;
    assign autobaud_done = done_q;
`else
    logic unused_rxd_s;
    assign unused_rxd_s = rxd;
    assign ab_load_s    = 1'b0;
    assign ab_int_s     = '0;
    assign ab_frac_s    = '0;
`endif

endmodule
